// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Multicycle sequencer for the RV32M divide/remainder path. It takes a decoded
// divider op and two 32-bit operands, runs a radix-2 restoring division with
// one quotient bit per cycle, and applies the RISC-V sign, divide-by-zero and
// signed-overflow rules. The result goes to the ALU result mux.
//
// Ports
//   clk        in   core clock, rising edge
//   resetn     in   synchronous active-low reset
//   DIVop      in   DIV_OP_DIV / DIV_OP_DIVU / DIV_OP_REM / DIV_OP_REMU
//   dividend   in   rs1 value
//   divisor    in   rs2 value
//   div_valid  in   request, held high by the control unit until div_ready
//   div_ready  out  one-cycle completion pulse (registered state DONE)
//   div_rdata  out  result, holds until the next accepted request
//   dbg_state  out  current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a request is accepted on any rising edge where the block is IDLE,
// div_valid=1 and resetn=1. Operands and DIVop are sampled only on that edge.
// div_ready is high for exactly one cycle per accepted request, and div_rdata
// is valid in that cycle. If div_valid is still high in the IDLE cycle after
// DONE, that is a new request.
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int                    DIV_STEPS    = 32,
  parameter int                    DIV_OP_WIDTH = 2,
  parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0,
  parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1,
  parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2,
  parameter logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DIV_OP_WIDTH-1:0] DIVop,
  input  logic [31:0]             dividend,
  input  logic [31:0]             divisor,
  input  logic                    div_valid,
  output logic                    div_ready,
  output logic [31:0]             div_rdata,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        quo_q, quo_d;
  logic [31:0]        dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;    // quotient op (DIV/DIVU) vs remainder op
  logic               neg_quo_q, neg_quo_d;  // signed op with differing operand signs
  logic               neg_rem_q, neg_rem_d;  // signed op with negative dividend
  logic [31:0]        rdata_q, rdata_d;

  // Request decode (only meaningful while IDLE)
  logic        req_is_div;
  logic        req_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div_zero;
  logic        sgn_ovf;

  // One restoring step
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] final_res;

  always_comb begin
    req_is_div = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_DIVU);
    req_signed = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
    a_neg      = req_signed & dividend[31];
    b_neg      = req_signed & divisor[31];
    // |0x80000000| wraps to 0x80000000, which the unsigned datapath handles.
    a_abs      = a_neg ? (~dividend + 32'd1) : dividend;
    b_abs      = b_neg ? (~divisor + 32'd1) : divisor;
    div_zero   = (divisor == 32'd0);
    sgn_ovf    = req_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  end

  always_comb begin
    // Remainder stays below the divisor, so the shifted value fits in 33 bits
    // and bit 32 of the 33-bit difference is a reliable borrow flag.
    rem_sh    = {rem_q, quo_q[31]};
    trial     = rem_sh - {1'b0, dvsr_q};
    step_rem  = trial[32] ? rem_sh[31:0] : trial[31:0];
    step_quo  = {quo_q[30:0], ~trial[32]};
    if (is_div_q) begin
      final_res = neg_quo_q ? (~step_quo + 32'd1) : step_quo;
    end else begin
      final_res = neg_rem_q ? (~step_rem + 32'd1) : step_rem;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (div_valid) begin
          is_div_d  = req_is_div;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero) begin
            rdata_d = req_is_div ? 32'hFFFF_FFFF : dividend;
            state_d = ST_DONE;
          end else if (sgn_ovf) begin
            rdata_d = req_is_div ? 32'h8000_0000 : 32'd0;
            state_d = ST_DONE;
          end else begin
            rem_d   = 32'd0;
            quo_d   = a_abs;
            dvsr_d  = b_abs;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          rdata_d = final_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rdata_q   <= rdata_d;
    end
  end

  assign div_ready = (state_q == ST_DONE);
  assign div_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Drives directed and random divider requests into div_sequencer. Every issued
// request pushes its expected result, expected latency and accept cycle into
// queues; a monitor pops and compares whenever div_ready is seen. Expected
// values come from plain integer division in ref_result.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic [31:0] div_rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  div_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .DIVop     (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_rdata (div_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_lat_q[$];
  int          issue_q[$];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return ((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (is_ovf(op, a, b)) return 32'h8000_0000;
               else return 32'(sa / sb);
      OP_DIVU: if (b == 0) return 32'hFFFF_FFFF;
               else return a / b;
      OP_REM:  if (b == 0) return a;
               else if (is_ovf(op, a, b)) return 32'd0;
               else return 32'(sa % sb);
      default: if (b == 0) return a;
               else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return ((b == 0) || is_ovf(op, a, b)) ? 1 : 33;
  endfunction

  // ---------------- driver ----------------
  // from_done: valid is being held across the previous DONE cycle, so the
  // request is accepted in the IDLE cycle that follows.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit from_done, input bit hold);
    bit done;
    if (!from_done) begin
      @(posedge clk); #1;
    end
    div_op    = op;
    dividend  = a;
    divisor   = b;
    div_valid = 1'b1;
    exp_q.push_back(ref_result(op, a, b));
    exp_lat_q.push_back(ref_latency(op, a, b));
    issue_q.push_back(from_done ? cyc + 1 : cyc);
    done = 1'b0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(posedge clk); #1;
      if (div_ready) done = 1'b1;
      else if (i == 5) begin
        // In-flight operand/op changes must not disturb the result.
        div_op   = 2'($urandom_range(0, 3));
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL ready_timeout: no div_ready within 60 cycles (op %0d a 0x%08h b 0x%08h)", op, a, b);
      exp_q.delete();
      exp_lat_q.delete();
      issue_q.delete();
      div_valid = 1'b0;
      resetn    = 1'b0;
      @(posedge clk); #1;
      resetn    = 1'b1;
    end else if (!hold) begin
      div_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic        prev_ready = 1'b0;
  logic [31:0] mon_exp;
  int          mon_lat;
  int          mon_issue;

  always @(posedge clk) begin
    #2;
    if (div_ready) begin
      chk("ready_single_cycle", 32'(prev_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got ready with rdata 0x%08h, expected no ready", div_rdata);
      end else begin
        mon_exp   = exp_q.pop_front();
        mon_lat   = exp_lat_q.pop_front();
        mon_issue = issue_q.pop_front();
        chk("result", div_rdata, mon_exp);
        chk("latency", 32'(cyc - mon_issue), 32'(mon_lat));
      end
    end
    prev_ready = div_ready;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit held;
    bit hold;
    logic [1:0] r_op;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(div_ready), 32'd0);
    chk("reset_rdata", div_rdata, 32'd0);
    resetn = 1'b1;

    // Directed cases
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(OP_REMU, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(OP_DIV,  32'd7, 32'd0, 1'b0, 1'b0);
    run_op(OP_REMU, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // Back-to-back with valid held across DONE
    run_op(OP_DIVU, 32'h1234_5678, 32'h0000_1234, 1'b0, 1'b1);
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
    run_op(OP_REMU, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
    run_op(OP_REM,  32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);

    // Reset in the middle of CALC: result discarded, never signalled
    @(posedge clk); #1;
    div_op    = OP_DIVU;
    dividend  = 32'd1000;
    divisor   = 32'd7;
    div_valid = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    resetn    = 1'b0;
    div_valid = 1'b0;
    @(posedge clk); #1;
    resetn    = 1'b1;
    chk("midcalc_reset_ready", 32'(div_ready), 32'd0);
    chk("midcalc_reset_rdata", div_rdata, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, 1'b0);

    // Reset coincident with a request in IDLE: reset wins
    @(posedge clk); #1;
    resetn    = 1'b0;
    div_op    = OP_DIV;
    dividend  = 32'd7;
    divisor   = 32'd0;
    div_valid = 1'b1;
    @(posedge clk); #1;
    resetn    = 1'b1;
    div_valid = 1'b0;
    chk("reset_vs_valid_rdata", div_rdata, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Random requests, some back-to-back
    held = 1'b0;
    for (int k = 0; k < 40; k++) begin
      hold = (k < 39) && ($urandom_range(0, 1) == 1);
      r_op = 2'($urandom_range(0, 3));
      run_op(r_op, rand_operand(), rand_operand(), held, hold);
      held = hold;
    end

    repeat (5) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multicycle sequencer for the RV32M divide/remainder path. It accepts a decoded divider operation and two 32-bit operands from the control unit, runs a 32-step radix-2 restoring division, and applies RISC-V sign, divide-by-zero and overflow rules. It returns the selected result with a one-cycle ready pulse. It sits between the divider decoder (`DIVop`, `div_valid`) and the ALU result mux in the multicycle core.

## Interface
- `DIV_STEPS`, default 32: iteration count, one quotient bit per step; fixed at 32 for RV32.
- `clk`  input  1  core clock; all state changes on rising edge.
- `resetn`  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `DIVop`  input  `DIV_OP_WIDTH`  operation code: `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM` or `DIV_OP_REMU`.
- `dividend`  input  32  rs1 value.
- `divisor`  input  32  rs2 value.
- `div_valid`  input  1  request; the control unit holds it high until `div_ready`.
- `div_ready`  output  1  one-cycle completion pulse.
- `div_rdata`  output  32  result; holds its value until the next accepted request.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if `div_valid`=1, accept the request and latch `DIVop`, operands and sign flags.
  - Divisor is zero, or the op is DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: precompute the result into `div_rdata` and go to DONE.
  - Otherwise: load remainder accumulator = 0, working quotient = |dividend| (signed ops) or raw dividend (unsigned ops), working divisor = |divisor| or raw divisor, step counter = 0, then go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted − divisor, computed as a 33-bit subtract.
  - If the trial is non-negative: rem = trial and quo LSB = 1. Otherwise rem = rem_shifted and quo LSB = 0.
  - Counter increments. After the step with counter = DIV_STEPS−1, write the final result to `div_rdata` and go to DONE.
- Final result:
  - DIV: quo, negated if the operand signs differ.
  - DIVU: quo.
  - REM: rem, negated if the dividend is negative.
  - REMU: rem.
- Special results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend unchanged.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- DONE: `div_ready`=1 for this cycle only, then go to IDLE unconditionally.
- Inputs are ignored outside IDLE. Changes to `DIVop` or operands during CALC or DONE have no effect.
- All negation and absolute value use 32-bit two's complement. |0x80000000| = 0x80000000, which is correct when treated as unsigned in the datapath.

## Timing
- Reset values: state = IDLE, `div_ready` = 0, `div_rdata` = 0x00000000, counter = 0.
- `div_ready` is decoded from the registered state (DONE) and has no combinational path from inputs.
- Normal latency: accept edge E0; CALC occupies the cycles after E0 through E32; `div_ready` is high for the cycle after E32. That is 33 cycles from accept to ready; `div_rdata` is valid in the same cycle.
- Fast path (divide by zero or overflow): `div_ready` is high in the cycle after E0, a latency of 1.
- The control unit drops `div_valid` on the edge that ends the DONE cycle. The block returns to IDLE on that same edge and therefore sees `div_valid`=0.
- If `div_valid` is still high in IDLE after DONE, that counts as a new request and is accepted. Back-to-back operations need no idle gap.
- `resetn`=0 in any state: on the next edge the block goes to IDLE, `div_ready`=0 and `div_rdata`=0. A partially computed result is discarded and never signalled.
- `resetn`=0 coincident with `div_valid`=1 in IDLE: reset wins and the request is not accepted.

## Test plan
- DIVU 100 / 7: `div_ready` high exactly 33 cycles after accept; `div_rdata`=14. REMU on the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM on the same operands → 0xFFFFFFFF (−1).
- DIV 7 / 0 → 0xFFFFFFFF and REMU 0x1234 / 0 → 0x1234, each with ready one cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0. Both take the 1-cycle path.
- Assert `resetn`=0 for one cycle at CALC step 10: no `div_ready` pulse and `div_rdata`=0. A fresh DIVU 9 / 3 afterwards → 3 after 33 cycles.
- Back-to-back requests with `div_valid` held across DONE: two results returned, each with a single-cycle ready pulse. Operands changed mid-CALC do not affect the in-flight result.
